imem_loader: RTL

- Writer end of the instruction-memory interface; the CPU fetch path is the reader.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit little-endian instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU (cpu_hold) while a load is in progress.
- Sits between the host byte source (UART receiver or bench) and the instruction memory write port.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: header (16-bit word count) + LE data words, written from address 0.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int BUS    = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [BUS-1:0]    mem_addr,
  output logic [BUS-1:0]    mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_e;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [BUS-1:0]    word_q, word_d;
  logic [BUS-1:0]    addr_q, addr_d;
  logic [BUS-1:0]    wdata_q, wdata_d;
  logic [ADDR_W:0]   wc_q, wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic              byte_fire;
  logic              load_go;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic [ADDR_W:0]   idx_inc;
  logic              last_word;
  logic [BUS-1:0]    word_shift;

  assign byte_fire  = byte_valid & byte_ready;
  assign hdr_n      = {byte_data, len_q[7:0]};
  assign hdr_bad    = (hdr_n == 16'd0) || ({1'b0, hdr_n} > DEPTH);
  assign idx_inc    = {1'b0, idx_q} + (ADDR_W+1)'(1);
  assign last_word  = (16'(idx_inc) == len_q);
  // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
  assign word_shift = {byte_data, word_q[BUS-1:8]};

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = wc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wc_q    <= wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wc_d       = wc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    load_go    = 1'b0;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        load_go  = start;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_fire) begin
          len_d   = {len_q[15:8], byte_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_fire) begin
          len_d   = hdr_n;
          state_d = hdr_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_fire) begin
          word_d = word_shift;
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            wdata_d = word_shift;
            addr_d  = BUS'({idx_q, 2'b00});
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        wc_d   = idx_inc;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_inc[ADDR_W-1:0];
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        load_go  = start;
      end
      S_ERR: begin
        error   = 1'b1;
        load_go = start;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (byte_fire) state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A fresh load always restarts at word 0 with cleared progress.
    if (load_go) begin
      state_d = S_LEN_LO;
      idx_d   = '0;
      wc_d    = '0;
      bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d   = '0;
`endif
    end
  end

endmodule
